// File: rtl/census_pkg.sv
// Shared constants and types for the census/Hamming and WTA disparity custom instructions.
package census_pkg;

   localparam int OP_W      = 4;
   localparam int WORD_W    = 32;
   localparam int COST_W    = 16;
   localparam int DISP_W    = 8;
   localparam int UNIQ_W    = 7;
   localparam int PROD_W    = COST_W + UNIQ_W;
   localparam int MUL_STEPS = UNIQ_W;

   localparam logic [COST_W-1:0] COST_MAX = 16'hFFFF;
   localparam logic [UNIQ_W-1:0] UNIQ_MAX = 7'd100;

   localparam logic [OP_W-1:0] OP_INIT    = 4'd0;
   localparam logic [OP_W-1:0] OP_PUSH    = 4'd1;
   localparam logic [OP_W-1:0] OP_PUSH2   = 4'd2;
   localparam logic [OP_W-1:0] OP_FINAL   = 4'd3;
   localparam logic [OP_W-1:0] OP_READ_NB = 4'd4;

   // Result field offsets: PUSH returns {0, bidx, best}; FINAL returns {best, 0, ovf, valid, bidx}.
   localparam int RES_PUSH_BEST_LSB = 0;
   localparam int RES_PUSH_BIDX_LSB = 16;
   localparam int RES_BEST_LSB      = 16;
   localparam int RES_OVF_BIT       = 9;
   localparam int RES_VALID_BIT     = 8;
   localparam int RES_BIDX_LSB      = 0;
   localparam int RES_CP1_LSB       = 16;
   localparam int RES_CM1_LSB       = 0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PUSH_HI,
      ST_MUL,
      ST_CMP
   } wta_state_e;

   typedef struct packed {
      logic [DISP_W-1:0] dcnt;
      logic [COST_W-1:0] best;
      logic [DISP_W-1:0] bidx;
      logic [COST_W-1:0] second;
      logic [COST_W-1:0] cm1;
      logic [COST_W-1:0] cp1;
      logic [COST_W-1:0] prev;
      logic              ovf;
   } track_t;

endpackage

// File: rtl/disparity_wta_if.sv
// Custom-instruction bus between the Nios II core (master) and the WTA unit (slave).
interface disparity_wta_if;
   logic                          iClk_en;
   logic                          iStart;
   logic [census_pkg::OP_W-1:0]   iOp;
   logic [census_pkg::WORD_W-1:0] iA;
   logic [census_pkg::WORD_W-1:0] iB;
   logic [census_pkg::WORD_W-1:0] oRes;
   logic                          oDone;

   modport master (
      output iClk_en, iStart, iOp, iA, iB,
      input  oRes, oDone
   );

   modport slave (
      input  iClk_en, iStart, iOp, iA, iB,
      output oRes, oDone
   );
endinterface

// File: rtl/serial_mul16x7.sv
// Shift-add multiplier, one multiplier bit per enabled cycle: 16x7 -> 23-bit product in 7 cycles.
module serial_mul16x7
   import census_pkg::*;
(
   input  logic              iClk,
   input  logic              iReset,
   input  logic              iEn,
   input  logic              iStart,
   input  logic [COST_W-1:0] iA,
   input  logic [UNIQ_W-1:0] iB,
   output logic              oBusy,
   output logic              oLast,
   output logic [PROD_W-1:0] oProd
);

   logic [PROD_W-1:0] acc_q, acc_d;
   logic [PROD_W-1:0] mcand_q, mcand_d;
   logic [UNIQ_W-1:0] mplier_q, mplier_d;
   logic [2:0]        cnt_q, cnt_d;
   logic              busy_q, busy_d;

   always_comb begin
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      if (iStart) begin
         acc_d    = '0;
         mcand_d  = {{(PROD_W-COST_W){1'b0}}, iA};
         mplier_d = iB;
         cnt_d    = 3'(MUL_STEPS);
         busy_d   = 1'b1;
      end else if (busy_q) begin
         if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
         end
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q - 3'd1;
         if (cnt_q == 3'd1) begin
            busy_d = 1'b0;
         end
      end
   end

   always_ff @(posedge iClk or negedge iReset) begin
      if (!iReset) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else if (iEn) begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
      end
   end

   assign oBusy = busy_q;
   assign oLast = busy_q && (cnt_q == 3'd1);
   assign oProd = acc_q;

endmodule

// File: rtl/disparity_wta.sv
// Winner-take-all disparity selector: tracks best/second cost and winner neighbours,
// then applies a uniqueness-ratio test on FINAL using two serial multipliers.
module disparity_wta
   import census_pkg::*;
(
   input  logic           iClk,
   input  logic           iReset,
   disparity_wta_if.slave bus
);

   wta_state_e        state_q, state_d;
   track_t            trk_q, trk_d;
   logic [DISP_W-1:0] dmax_q, dmax_d;
   logic [UNIQ_W-1:0] uniq_q, uniq_d;
   logic [COST_W-1:0] hi_q, hi_d;
   logic [WORD_W-1:0] res_q, res_d;
   logic              done_q, done_d;

   logic              mul_start;
   logic              p1_busy, p1_last, p2_busy, p2_last;
   logic [PROD_W-1:0] p1, p2;
   logic              valid;
   logic              unused_bits;

   assign unused_bits = ^bus.iB[WORD_W-1:UNIQ_W];

   function automatic track_t wta_update(input track_t s, input logic [DISP_W-1:0] dmax,
                                         input logic [COST_W-1:0] c);
      track_t n;
      n = s;
      if (s.dcnt >= dmax) begin
         n.ovf = 1'b1;
      end else begin
         // Strict compare: on a tie the earlier (lower) disparity stays the winner.
         if (c < s.best) begin
            n.second = s.best;
            n.cm1    = s.prev;
            n.cp1    = COST_MAX;
            n.best   = c;
            n.bidx   = s.dcnt;
         end else begin
            if (c < s.second) begin
               n.second = c;
            end
            if ({1'b0, s.dcnt} == ({1'b0, s.bidx} + 9'd1)) begin
               n.cp1 = c;
            end
         end
         n.prev = c;
         n.dcnt = s.dcnt + 8'd1;
      end
      return n;
   endfunction

   function automatic logic [WORD_W-1:0] push_result(input track_t s);
      logic [WORD_W-1:0] r;
      r = '0;
      r[RES_PUSH_BEST_LSB +: COST_W] = s.best;
      r[RES_PUSH_BIDX_LSB +: DISP_W] = s.bidx;
      return r;
   endfunction

   assign valid = (trk_q.dcnt == dmax_q) && (dmax_q != '0) &&
                  (trk_q.best != COST_MAX) && (p2 >= p1);

   always_comb begin
      state_d   = state_q;
      trk_d     = trk_q;
      dmax_d    = dmax_q;
      uniq_d    = uniq_q;
      hi_d      = hi_q;
      res_d     = res_q;
      done_d    = 1'b0;
      mul_start = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.iStart) begin
               done_d = 1'b1;
               case (bus.iOp)
                  OP_INIT: begin
                     dmax_d       = bus.iA[DISP_W-1:0];
                     uniq_d       = (bus.iB[UNIQ_W-1:0] > UNIQ_MAX) ? UNIQ_MAX : bus.iB[UNIQ_W-1:0];
                     trk_d.dcnt   = '0;
                     trk_d.bidx   = '0;
                     trk_d.ovf    = 1'b0;
                     trk_d.best   = COST_MAX;
                     trk_d.second = COST_MAX;
                     trk_d.cm1    = COST_MAX;
                     trk_d.cp1    = COST_MAX;
                     trk_d.prev   = COST_MAX;
                     res_d        = '0;
                  end
                  OP_PUSH: begin
                     trk_d = wta_update(trk_q, dmax_q, bus.iA[COST_W-1:0]);
                     res_d = push_result(trk_d);
                  end
                  OP_PUSH2: begin
                     trk_d   = wta_update(trk_q, dmax_q, bus.iA[COST_W-1:0]);
                     hi_d    = bus.iA[WORD_W-1:COST_W];
                     done_d  = 1'b0;
                     state_d = ST_PUSH_HI;
                  end
                  OP_FINAL: begin
                     mul_start = 1'b1;
                     done_d    = 1'b0;
                     state_d   = ST_MUL;
                  end
                  OP_READ_NB: begin
                     res_d = '0;
                     res_d[RES_CP1_LSB +: COST_W] = trk_q.cp1;
                     res_d[RES_CM1_LSB +: COST_W] = trk_q.cm1;
                  end
                  default: begin
                     res_d = '0;
                  end
               endcase
            end
         end
         ST_PUSH_HI: begin
            trk_d   = wta_update(trk_q, dmax_q, hi_q);
            res_d   = push_result(trk_d);
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         ST_MUL: begin
            // Both multipliers start together, so their last-step flags coincide.
            if (!(p1_busy || p2_busy) || (p1_last && p2_last)) begin
               state_d = ST_CMP;
            end
         end
         ST_CMP: begin
            res_d = '0;
            res_d[RES_BEST_LSB +: COST_W] = trk_q.best;
            res_d[RES_OVF_BIT]            = trk_q.ovf;
            res_d[RES_VALID_BIT]          = valid;
            res_d[RES_BIDX_LSB +: DISP_W] = trk_q.bidx;
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge iClk or negedge iReset) begin
      if (!iReset) begin
         state_q <= ST_IDLE;
         trk_q   <= '0;
         dmax_q  <= '0;
         uniq_q  <= '0;
         hi_q    <= '0;
         res_q   <= '0;
         done_q  <= 1'b0;
      end else if (bus.iClk_en) begin
         state_q <= state_d;
         trk_q   <= trk_d;
         dmax_q  <= dmax_d;
         uniq_q  <= uniq_d;
         hi_q    <= hi_d;
         res_q   <= res_d;
         done_q  <= done_d;
      end
   end

   serial_mul16x7 u_mul_p1 (
      .iClk   (iClk),
      .iReset (iReset),
      .iEn    (bus.iClk_en),
      .iStart (mul_start),
      .iA     (trk_q.best),
      .iB     (UNIQ_MAX),
      .oBusy  (p1_busy),
      .oLast  (p1_last),
      .oProd  (p1)
   );

   serial_mul16x7 u_mul_p2 (
      .iClk   (iClk),
      .iReset (iReset),
      .iEn    (bus.iClk_en),
      .iStart (mul_start),
      .iA     (trk_q.second),
      .iB     (UNIQ_MAX - uniq_q),
      .oBusy  (p2_busy),
      .oLast  (p2_last),
      .oProd  (p2)
   );

   assign bus.oRes  = res_q;
   assign bus.oDone = done_q;

endmodule

// File: tb/tb_disparity_wta.sv
// Bench for disparity_wta: fixed vector table, stall/poke/reset sequences, random ops vs a list-based model.
module tb_disparity_wta;
   import census_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   disparity_wta_if bus();

   disparity_wta dut (
      .iClk   (clk),
      .iReset (rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t tbl[$];

   // Reference model: the list of accepted costs since INIT.
   int unsigned m_costs[$];
   int          m_dmax;
   int          m_u;
   bit          m_ovf;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic void add(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp, input int lat);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
      tbl.push_back(v);
   endfunction

   function automatic void m_init(input logic [31:0] a, input logic [31:0] b);
      m_costs.delete();
      m_dmax = int'(a[7:0]);
      m_u    = (int'(b[6:0]) > 100) ? 100 : int'(b[6:0]);
      m_ovf  = 1'b0;
   endfunction

   function automatic void m_push(input logic [15:0] c);
      if (m_costs.size() >= m_dmax) m_ovf = 1'b1;
      else m_costs.push_back(int'(c));
   endfunction

   function automatic void m_stats(output int best, output int second, output int bidx);
      int unsigned s[$];
      s = m_costs;
      s.push_back(65535);
      s.push_back(65535);
      s.sort();
      best   = int'(s[0]);
      second = int'(s[1]);
      bidx   = 0;
      for (int i = m_costs.size() - 1; i >= 0; i--) begin
         if (m_costs[i] == s[0]) bidx = i;
      end
   endfunction

   function automatic logic [31:0] m_push_res();
      int best, second, bidx;
      logic [15:0] b16;
      logic [7:0]  i8;
      m_stats(best, second, bidx);
      b16 = best[15:0];
      i8  = bidx[7:0];
      return {8'd0, i8, b16};
   endfunction

   function automatic logic [31:0] m_final_res();
      int best, second, bidx;
      bit valid;
      logic [15:0] b16;
      logic [7:0]  i8;
      m_stats(best, second, bidx);
      valid = (m_costs.size() == m_dmax) && (m_dmax != 0) && (best != 65535) &&
              (longint'(second) * longint'(100 - m_u) >= longint'(best) * 100);
      b16 = best[15:0];
      i8  = bidx[7:0];
      return {b16, 6'd0, m_ovf, valid, i8};
   endfunction

   function automatic logic [31:0] m_nb_res();
      int best, second, bidx;
      int cm1, cp1;
      logic [15:0] m16, p16;
      m_stats(best, second, bidx);
      cm1 = (bidx > 0) ? int'(m_costs[bidx-1]) : 65535;
      cp1 = (bidx + 1 < m_costs.size()) ? int'(m_costs[bidx+1]) : 65535;
      m16 = cm1[15:0];
      p16 = cp1[15:0];
      return {p16, m16};
   endfunction

   function automatic logic [15:0] gen_cost();
      int r;
      logic [31:0] w;
      r = $urandom_range(0, 9);
      w = $urandom();
      if (r == 0) return 16'hFFFF;
      if (r == 1) return w[15:0];
      return 16'($urandom_range(0, 40));
   endfunction

   // Issues one op; stall_at/poke_at are cycle offsets after the start edge (-1 = none).
   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int stall_at, input int stall_len,
                         input int poke_at, output logic [31:0] res, output int en_lat,
                         output int real_lat);
      bit seen;
      seen = 1'b0;
      res = '0;
      en_lat = 0;
      real_lat = 0;
      @(negedge clk);
      bus.iStart = 1'b1; bus.iOp = op; bus.iA = a; bus.iB = b; bus.iClk_en = 1'b1;
      @(posedge clk); #1;
      bus.iStart = 1'b0;
      for (int k = 0; k < 64 && !seen; k++) begin
         if (bus.oDone === 1'b1) begin
            seen = 1'b1;
            res = bus.oRes;
         end else begin
            bus.iClk_en = !(stall_at >= 0 && real_lat >= stall_at && real_lat < stall_at + stall_len);
            if (real_lat == poke_at) begin
               bus.iStart = 1'b1; bus.iOp = OP_PUSH; bus.iA = 32'd1;
            end else begin
               bus.iStart = 1'b0;
            end
            @(posedge clk); #1;
            real_lat++;
            if (bus.iClk_en) en_lat++;
         end
      end
      bus.iStart = 1'b0;
      bus.iClk_en = 1'b1;
      check_int({tag, " done_seen"}, int'(seen), 1);
      if (seen) begin
         @(posedge clk); #1;
         check_int({tag, " done_pulse_width"}, int'(bus.oDone), 0);
      end
   endtask

   task automatic op_check(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input int lat);
      logic [31:0] res;
      int el, rl;
      run_op(tag, op, a, b, -1, 0, -1, res, el, rl);
      check32({tag, " res"}, res, exp);
      check_int({tag, " latency"}, el, lat);
      $display("op %0d a=%08h b=%08h -> res=%08h lat=%0d", op, a, b, res, el);
   endtask

   initial begin
      logic [31:0] res, a, b;
      int el, rl, npush, stuck;

      bus.iClk_en = 1'b1; bus.iStart = 1'b0; bus.iOp = '0; bus.iA = '0; bus.iB = '0;
      repeat (3) @(posedge clk);
      #1;
      check_int("reset oDone", int'(bus.oDone), 0);
      check32("reset oRes", bus.oRes, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Before INIT dmax=0: pushes only set ovf.
      add(OP_PUSH,    32'd5,        32'd0,  32'h00000000, 0);
      add(OP_FINAL,   32'd0,        32'd0,  32'h00000200, 8);
      add(OP_READ_NB, 32'd0,        32'd0,  32'h00000000, 0);
      add(OP_INIT,    32'd4,        32'd10, 32'h00000000, 0);
      add(OP_PUSH,    32'd50,       32'd0,  32'h00000032, 0);
      add(OP_PUSH,    32'd30,       32'd0,  32'h0001001E, 0);
      add(OP_PUSH,    32'd40,       32'd0,  32'h0001001E, 0);
      add(OP_PUSH,    32'd60,       32'd0,  32'h0001001E, 0);
      add(OP_FINAL,   32'd0,        32'd0,  32'h001E0101, 8);
      add(4'd9,       32'd0,        32'd0,  32'h00000000, 0);
      add(OP_READ_NB, 32'd0,        32'd0,  32'h00280032, 0);
      add(4'd15,      32'd0,        32'd0,  32'h00000000, 0);
      add(OP_INIT,    32'd2,        32'd0,  32'h00000000, 0);
      add(OP_PUSH,    32'd20,       32'd0,  32'h00000014, 0);
      add(OP_PUSH,    32'd20,       32'd0,  32'h00000014, 0);
      add(OP_FINAL,   32'd0,        32'd0,  32'h00140100, 8);
      add(OP_INIT,    32'd2,        32'd10, 32'h00000000, 0);
      add(OP_PUSH,    32'd20,       32'd0,  32'h00000014, 0);
      add(OP_PUSH,    32'd20,       32'd0,  32'h00000014, 0);
      add(OP_FINAL,   32'd0,        32'd0,  32'h00140000, 8);
      add(OP_INIT,    32'd2,        32'd0,  32'h00000000, 0);
      add(OP_PUSH,    32'd7,        32'd0,  32'h00000007, 0);
      add(OP_PUSH,    32'd9,        32'd0,  32'h00000007, 0);
      add(OP_PUSH,    32'd3,        32'd0,  32'h00000007, 0);
      add(OP_FINAL,   32'd0,        32'd0,  32'h00070300, 8);
      add(OP_INIT,    32'd4,        32'd0,  32'h00000000, 0);
      add(OP_PUSH2,   32'h0005000A, 32'd0,  32'h00010005, 1);
      add(OP_FINAL,   32'd0,        32'd0,  32'h00050001, 8);
      // U above 100 clamps to 100, so the ratio test cannot pass.
      add(OP_INIT,    32'd1,        32'h7F, 32'h00000000, 0);
      add(OP_PUSH,    32'd10,       32'd0,  32'h0000000A, 0);
      add(OP_FINAL,   32'd0,        32'd0,  32'h000A0000, 8);
      add(OP_INIT,    32'd2,        32'd0,  32'h00000000, 0);
      add(OP_PUSH,    32'd10,       32'd0,  32'h0000000A, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         op_check($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].lat);
      end

      // iStart during MUL must be ignored.
      run_op("poke", OP_FINAL, 32'd0, 32'd0, -1, 0, 3, res, el, rl);
      check32("poke final res", res, 32'h000A0000);
      check_int("poke final latency", el, 8);
      op_check("poke read_nb", OP_READ_NB, 32'd0, 32'd0, 32'hFFFFFFFF, 0);

      // Clock-enable stall during MUL.
      op_check("stall init", OP_INIT, 32'd4, 32'd10, 32'h0, 0);
      op_check("stall p0", OP_PUSH, 32'd50, 32'd0, 32'h00000032, 0);
      op_check("stall p1", OP_PUSH, 32'd30, 32'd0, 32'h0001001E, 0);
      op_check("stall p2", OP_PUSH, 32'd40, 32'd0, 32'h0001001E, 0);
      op_check("stall p3", OP_PUSH, 32'd60, 32'd0, 32'h0001001E, 0);
      run_op("stall", OP_FINAL, 32'd0, 32'd0, 2, 3, -1, res, el, rl);
      check32("stall final res", res, 32'h001E0101);
      check_int("stall enabled latency", el, 8);
      check_int("stall real latency", rl, 11);
      $display("stalled FINAL -> res=%08h en_lat=%0d real_lat=%0d", res, el, rl);

      // Reset in the middle of MUL aborts without a completion.
      @(negedge clk);
      bus.iStart = 1'b1; bus.iOp = OP_FINAL; bus.iA = '0; bus.iB = '0;
      @(posedge clk); #1;
      bus.iStart = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check32("abort oRes", bus.oRes, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      stuck = 0;
      for (int k = 0; k < 15; k++) begin
         @(posedge clk); #1;
         if (bus.oDone === 1'b1) stuck++;
      end
      check_int("abort no oDone", stuck, 0);
      check32("abort oRes after", bus.oRes, 32'h0);
      $display("reset abort during MUL -> spurious oDone=%0d", stuck);
      op_check("post-reset init", OP_INIT, 32'd3, 32'd0, 32'h0, 0);
      op_check("post-reset push", OP_PUSH, 32'd9, 32'd0, 32'h00000009, 0);
      op_check("post-reset nb", OP_READ_NB, 32'd0, 32'd0, 32'hFFFFFFFF, 0);

      // Random sessions against the reference model.
      for (int r = 0; r < 30; r++) begin
         a = $urandom();
         a[7:0] = 8'($urandom_range(0, 10));
         b = $urandom();
         m_init(a, b);
         op_check($sformatf("rnd%0d init", r), OP_INIT, a, b, 32'h0, 0);
         npush = $urandom_range(0, m_dmax + 3);
         for (int p = 0; p < npush; p++) begin
            logic [15:0] lo, hi;
            lo = gen_cost();
            hi = gen_cost();
            if ($urandom_range(0, 2) == 0) begin
               m_push(lo);
               m_push(hi);
               op_check($sformatf("rnd%0d push2_%0d", r, p), OP_PUSH2, {hi, lo}, 32'd0, m_push_res(), 1);
            end else begin
               m_push(lo);
               op_check($sformatf("rnd%0d push_%0d", r, p), OP_PUSH, {hi, lo}, 32'd0, m_push_res(), 0);
            end
         end
         op_check($sformatf("rnd%0d final", r), OP_FINAL, $urandom(), $urandom(), m_final_res(), 8);
         op_check($sformatf("rnd%0d read_nb", r), OP_READ_NB, 32'd0, 32'd0, m_nb_res(), 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
